// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Word-addressed memory/I-O slave for a simple CPU bus. Every access walks
//   IDLE -> ACCESS -> ACK, one cycle per state. At most one access completes
//   every three cycles.
//
//   Handshake: the CPU holds req high with address/data_in/rw valid. The
//   request is latched on the first rising edge seen in IDLE. Bus inputs are
//   ignored in ACCESS and ACK. The access completes with a single-cycle ack
//   pulse. err is meaningful only while ack=1 and is 0 otherwise.
//
//   Address map (word addresses, decoded from the latched address):
//     [0, 2^DEPTH_LOG2)  RAM, read/write
//     IO_BASE+0          io_out register, read/write (a write pulses io_wr)
//     IO_BASE+1          cycle_cnt, read-only (writes ignored, err=0)
//     IO_BASE+2          wr_cnt, read-only (writes ignored, err=0)
//     anything else      unmapped: ack with err=1, reads return 0
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high reset (RAM contents are kept)
//   address    word address from the CPU
//   data_in    write data from the CPU
//   rw         1 = read, 0 = write
//   req        access request
//   data_out   read data, held until the next completed read
//   ack        one-cycle access-complete pulse
//   err        unmapped-address flag, qualified by ack
//   io_out     output-port register
//   io_wr      one-cycle pulse when io_out has just been written
//   dbg_state  current FSM state (0 = IDLE, 1 = ACCESS, 2 = ACK)
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        rw,
  input  logic        req,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        err,
  output logic [31:0] io_out,
  output logic        io_wr,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rw;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_wr_cnt;
  logic [31:0] r_data_out;
  logic [31:0] r_io_out;
  logic        r_ack;
  logic        r_err;
  logic        r_io_wr;
  logic [31:0] r_mem [2**DEPTH_LOG2];

  logic [31:0]           w_io_off;
  logic                  w_ram_hit;
  logic                  w_io_out_hit;
  logic                  w_cyc_hit;
  logic                  w_wrc_hit;
  logic                  w_mapped;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           w_rd_data;

  // Decode works on the latched request only, so the bus is free to change
  // during ACCESS and ACK. RAM wins if the I/O window is ever placed inside it.
  always_comb begin
    w_io_off     = r_addr - IO_BASE;
    w_idx        = r_addr[DEPTH_LOG2-1:0];
    w_ram_hit    = (r_addr >> DEPTH_LOG2) == 32'd0;
    w_io_out_hit = !w_ram_hit && (w_io_off == 32'd0);
    w_cyc_hit    = !w_ram_hit && (w_io_off == 32'd1);
    w_wrc_hit    = !w_ram_hit && (w_io_off == 32'd2);
    w_mapped     = w_ram_hit || w_io_out_hit || w_cyc_hit || w_wrc_hit;
    w_rd_data    = 32'd0;
    if (w_ram_hit)         w_rd_data = r_mem[w_idx];
    else if (w_io_out_hit) w_rd_data = r_io_out;
    else if (w_cyc_hit)    w_rd_data = r_cycle_cnt;
    else if (w_wrc_hit)    w_rd_data = r_wr_cnt;
  end

  // FSM, counters and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_rw        <= 1'b1;
      r_cycle_cnt <= 32'd0;
      r_wr_cnt    <= 32'd0;
      r_data_out  <= 32'd0;
      r_io_out    <= 32'd0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_io_wr     <= 1'b0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_io_wr     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_addr  <= address;
            r_wdata <= data_in;
            r_rw    <= rw;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_state <= ST_ACK;
          r_ack   <= 1'b1;
          r_err   <= !w_mapped;
          if (r_rw) begin
            r_data_out <= w_rd_data;
          end else begin
            if (w_io_out_hit) begin
              r_io_out <= r_wdata;
              r_io_wr  <= 1'b1;
            end
            // Only writes that actually land somewhere are counted.
            if (w_ram_hit || w_io_out_hit) r_wr_cnt <= r_wr_cnt + 32'd1;
          end
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM has no reset; reset during ACCESS suppresses the pending write.
  always_ff @(posedge clock) begin
    if (!reset && (r_state == ST_ACCESS) && !r_rw && w_ram_hit) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign data_out  = r_data_out;
  assign ack       = r_ack;
  assign err       = r_err;
  assign io_out    = r_io_out;
  assign io_wr     = r_io_wr;
  assign dbg_state = r_state;

endmodule
